// File: rtl/seq_gen_pkg.sv
// Shared types for the serial pattern generator:
// FSM state encoding and the default pass-length type.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int DEF_WIDTH = 8;

    typedef logic [$clog2(DEF_WIDTH+1)-1:0] len_t;

endpackage

// File: rtl/seq_piso.sv
// Parallel-in/serial-out register; the loaded word is left-aligned
// so bit len-1 sits at the MSB and leaves first.
module seq_piso #(
    parameter int WIDTH = 8,
    parameter int LW    = $clog2(WIDTH+1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    input  logic [LW-1:0]    len,
    output logic             head,
    output logic             msb,
    output logic             next
);

    localparam logic [LW-1:0] FULL = LW'(WIDTH);

    logic [WIDTH-1:0] aligned;
    logic [WIDTH-1:0] sreg;

    assign aligned = data << (FULL - len);
    assign head    = aligned[WIDTH-1];
    assign msb     = sreg[WIDTH-1];
    assign next    = sreg[WIDTH-2];

    // Zero fill means the register drains to 0 once a pass is shifted out
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= aligned;
        end else if (shift) begin
            sreg <= sreg << 1;
        end
    end

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: emits the low load_len bits MSB-first,
// repeated load_repeat extra times, with a same-as-previous-bit flag.
module seq_pattern_gen
    import seq_gen_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [WIDTH-1:0]           load_data,
    input  logic [$clog2(WIDTH+1)-1:0] load_len,
    input  logic [CNT_W-1:0]           load_repeat,
    output logic                       serial_out,
    output logic                       out_valid,
    output logic                       pair_flag,
    output logic                       done
);

    localparam int LW = $clog2(WIDTH+1);
    localparam logic [LW-1:0] FULL = LW'(WIDTH);

    state_t           state;
    logic [LW-1:0]    bit_cnt;
    logic [LW-1:0]    len_q;
    logic [CNT_W-1:0] rep_cnt;
    logic [WIDTH-1:0] saved;

    logic [LW-1:0]    eff_len;
    logic             reload;
    logic             piso_load;
    logic             piso_shift;
    logic [WIDTH-1:0] piso_data;
    logic [LW-1:0]    piso_len;
    logic             piso_head;
    logic             piso_next;

    assign load_ready = (state == IDLE);

    assign eff_len = (load_len == '0 || load_len > FULL) ? FULL : load_len;

    assign reload = (state == SHIFT) && (bit_cnt == LW'(1))
                    && (rep_cnt != '0);

    assign piso_load  = (load_ready && load_valid) || reload;
    assign piso_shift = (state == SHIFT) && !reload;
    assign piso_data  = load_ready ? load_data : saved;
    assign piso_len   = load_ready ? eff_len : len_q;

    seq_piso #(
        .WIDTH (WIDTH),
        .LW    (LW)
    ) u_piso (
        .clk   (clk),
        .reset (reset),
        .load  (piso_load),
        .shift (piso_shift),
        .data  (piso_data),
        .len   (piso_len),
        .head  (piso_head),
        .msb   (serial_out),
        .next  (piso_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            len_q     <= '0;
            rep_cnt   <= '0;
            saved     <= '0;
            out_valid <= 1'b0;
            pair_flag <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (load_valid) begin
                        saved     <= load_data;
                        len_q     <= eff_len;
                        bit_cnt   <= eff_len;
                        rep_cnt   <= load_repeat;
                        out_valid <= 1'b1;
                        pair_flag <= 1'b0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_cnt == LW'(1)) begin
                        if (rep_cnt != '0) begin
                            // Next pass starts with no gap
                            rep_cnt   <= rep_cnt - CNT_W'(1);
                            bit_cnt   <= len_q;
                            pair_flag <= (piso_head == serial_out);
                        end else begin
                            out_valid <= 1'b0;
                            pair_flag <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end else begin
                        bit_cnt   <= bit_cnt - LW'(1);
                        pair_flag <= (piso_next == serial_out);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: each accepted load queues its
// expected bit stream; a negedge monitor pops and compares.
module tb_seq_pattern_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [7:0] load_data = '0;
    logic [3:0] load_len = '0;
    logic [3:0] load_repeat = '0;
    logic       serial_out;
    logic       out_valid;
    logic       pair_flag;
    logic       done;

    typedef struct {
        logic is_done;
        logic b;
        logic p;
        logic first;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_accept = 0;
    int   last_span = 0;
    logic prev_done = 1'b0;

    seq_pattern_gen #(
        .WIDTH (8),
        .CNT_W (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .load_len    (load_len),
        .load_repeat (load_repeat),
        .serial_out  (serial_out),
        .out_valid   (out_valid),
        .pair_flag   (pair_flag),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endfunction

    // Reference stream: pass = d[eff-1:0] MSB first, repeated r+1 times
    task automatic push_expect(input logic [7:0] d, input int l,
                               input int r);
        int   eff;
        logic bits[$];
        exp_t e;
        eff = (l == 0 || l > 8) ? 8 : l;
        for (int p = 0; p <= r; p++)
            for (int i = eff - 1; i >= 0; i--)
                bits.push_back(d[i]);
        for (int i = 0; i < bits.size(); i++) begin
            e.is_done = 1'b0;
            e.b       = bits[i];
            e.p       = (i > 0) && (bits[i] == bits[i-1]);
            e.first   = (i == 0);
            exp_q.push_back(e);
        end
        e.is_done = 1'b1;
        e.b       = 1'b0;
        e.p       = 1'b0;
        e.first   = 1'b0;
        exp_q.push_back(e);
        last_span = bits.size();
    endtask

    // Called at a negedge; leaves load_valid high on return
    task automatic send(input logic [7:0] d, input int l, input int r,
                        input bit spacing);
        int n;
        int span_prev;
        n = 0;
        span_prev   = last_span;
        load_data   = d;
        load_len    = 4'(l);
        load_repeat = 4'(r);
        load_valid  = 1'b1;
        while (!load_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!load_ready) begin
            chk("accept_timeout", 0, 1);
        end else begin
            if (spacing)
                chk("accept_spacing", cyc - last_accept, span_prev + 2);
            last_accept = cyc;
            push_expect(d, l, r);
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (out_valid || done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", {out_valid, done}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_valid", out_valid, !e.is_done);
                    chk("done", done, e.is_done);
                    if (!e.is_done) begin
                        chk("serial_out", serial_out, e.b);
                        chk("pair_flag", pair_flag, e.p);
                    end
                end
                chk("ready_busy", load_ready, 0);
            end else begin
                chk("idle_serial", {serial_out, pair_flag}, 0);
                if (exp_q.size() > 0 && !exp_q[0].first)
                    chk("burst_gap", 1, 0);
            end
            if (prev_done)
                chk("ready_after_done", load_ready, 1);
            prev_done = done;
        end
    end

    initial begin
        logic [7:0] d;
        int         l;
        int         r;
        bit         held;
        int         n;

        @(negedge clk);
        chk("rst_ready", load_ready, 1);
        chk("rst_outs", {serial_out, out_valid, pair_flag, done}, 0);
        @(negedge clk);
        #1 reset = 1'b1;

        send(8'hB2, 8, 0, 0);
        load_valid = 1'b0;
        send(8'h05, 3, 2, 0);
        load_valid = 1'b0;
        send(8'hF0, 0, 0, 0);
        send(8'h3C, 13, 1, 1);
        send(8'h5A, 4, 0, 1);
        load_valid = 1'b0;

        // Asynchronous reset during bit 4 of an 8-bit burst
        send(8'hA7, 8, 0, 0);
        load_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_outs", {serial_out, out_valid, pair_flag, done}, 0);
        chk("midrst_ready", load_ready, 1);
        exp_q.delete();
        prev_done = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
        send(8'h6D, 8, 0, 0);
        load_valid = 1'b0;

        send(8'h01, 1, 15, 0);
        load_valid = 1'b0;

        held = 1'b0;
        for (int k = 0; k < 30; k++) begin
            d = 8'($urandom);
            l = $urandom_range(0, 15);
            r = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15)
                                            : $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 0) begin
                load_valid = 1'b0;
                repeat ($urandom_range(0, 5)) @(negedge clk);
                held = 1'b0;
            end
            send(d, l, r, held);
            held = 1'b1;
        end
        load_valid = 1'b0;

        n = 0;
        while (exp_q.size() > 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_pattern_gen.md
# seq_pattern_gen

Serial pattern transmitter: accepts a parallel word through a valid/ready load port and emits its lowest `load_len` bits MSB-first on a one-bit serial line, optionally repeating the pass. It is the stimulus end of our serial sequence-detection path. It drives the single-bit input of the two-consecutive-equal-bits Moore detector. It also produces its own registered `pair_flag` so the bench can compare it against the detector's `detect` output.

## Interface
Parameters:
- `WIDTH`, 8: load word width; one pass emits at most WIDTH bits.
- `CNT_W`, 4: repeat-count width.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `load_valid`  in  1  load request.
- `load_ready`  out  1  high exactly when state is IDLE; combinational from state.
- `load_data`  in  WIDTH  pattern; bits [len-1:0] are emitted.
- `load_len`  in  $clog2(WIDTH+1)  bits per pass; 0 means WIDTH; values above WIDTH are clamped to WIDTH.
- `load_repeat`  in  CNT_W  extra passes; total passes = load_repeat+1.
- `serial_out`  out  1  serial bit, registered.
- `out_valid`  out  1  `serial_out` carries a pattern bit, registered.
- `pair_flag`  out  1  current bit equals previous bit of same burst, registered.
- `done`  out  1  one-cycle pulse after the final bit, registered.

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE:**
  - `load_ready`=1.
  - When `load_valid`=1 at a rising edge: the load is accepted.
    - Capture `load_data`, the effective len, and `load_repeat`.
    - Keep a copy of the pattern for repeats.
  - The next state is SHIFT.
- **SHIFT:**
  - Emits one bit per cycle: `load_data[len-1]` first, down to `load_data[0]`.
  - At the end of a pass, the repeat counter is checked:
    - Nonzero: decrement it and reload from the saved copy with no gap.
    - Zero: go to DONE.
- **DONE:**
  - Lasts one cycle with `done`=1, `out_valid`=0 and `load_ready`=0.
  - Then returns to IDLE.
- **`pair_flag`:**
  - Asserted with a bit when `out_valid`=1 and that bit equals the previously emitted bit of the same burst.
  - The first bit of a burst always has `pair_flag`=0.
  - A repeat boundary is contiguous and is compared like any other pair of bits.
- **`serial_out` when `out_valid`=0:** held at 0.
- **Load attempts while busy:** `load_valid` during SHIFT or DONE is ignored (`load_ready`=0). The sender must hold the request until IDLE.
- **Counter width:** the repeat counter is CNT_W bits and never wraps. With `load_repeat`=2^CNT_W−1, 2^CNT_W passes are emitted.

## Timing
- **Reset values:**
  - State is IDLE.
  - `load_ready`=1.
  - `serial_out`, `out_valid`, `pair_flag` and `done` are 0.
  - All internal registers are cleared.
- **Reset mid-burst:**
  - Outputs go to their reset values immediately, without waiting for `clk`.
  - The burst is abandoned and nothing resumes.
  - A load is accepted on the first edge after release.
- **Latency:** first bit is valid in the cycle immediately after the accepting edge.
- **Burst length:** `out_valid` stays high for exactly len×(repeat+1) consecutive cycles.
- **`done`:** high in the cycle after the last bit.
- **IDLE re-entry:** IDLE (`load_ready`=1) is re-entered one cycle after that.
- **Back-to-back loads:** the minimum accept-to-accept spacing is len×(repeat+1)+2 cycles.

## Structure
- **Package `seq_gen_pkg`:** holds the state enum (IDLE, SHIFT, DONE) and a `len_t` typedef sized $clog2(WIDTH+1).
- **Sub-module `seq_piso`:**
  - Parameterised WIDTH parallel-in/serial-out shift register.
  - Inputs: load, shift, len.
  - Behaviour: on load, the data is left-aligned by WIDTH−len; the MSB is output.
  - It is instantiated once. The FSM, bit counter, repeat counter and flag logic stay in the top module.

## Test plan
- Reset released; load 8'b1011_0010, len=8, repeat=0:
  - `serial_out` is 1,0,1,1,0,0,1,0 on the 8 cycles after the accepting edge.
  - `pair_flag` is 0,0,0,1,0,1,0,0.
  - `done` pulses in cycle 9.
  - `load_ready` returns in cycle 10.
- Load 8'h05, len=3, repeat=2:
  - `serial_out` is 1,0,1,1,0,1,1,0,1 over 9 cycles.
  - `pair_flag` is high only on bits 4 and 7 (1-based).
  - `done` pulses in cycle 10.
- Load len=0 with 8'hF0:
  - Treated as len=8.
  - Emits 1,1,1,1,0,0,0,0.
  - `pair_flag` is 0,1,1,1,0,1,1,1.
- Hold `load_valid` high continuously with a second word queued behind the first:
  - The second accept occurs only on the edge ending the first IDLE cycle after `done`.
  - No bits are dropped or merged between bursts.
- Assert `reset`=0 asynchronously during bit 4 of an 8-bit burst:
  - `out_valid`, `serial_out`, `pair_flag` and `done` drop to 0 before the next edge.
  - `load_ready`=1.
  - A fresh load after release emits correctly from its first bit.
- len=1, data=1, repeat=15 (CNT_W=4):
  - Emits 16 consecutive 1s.
  - `pair_flag` is high on bits 2–16.
  - `done` pulses once.
